// File: rtl/lvds_align_pkg.sv
// Shared definitions for the LVDS receive word aligner: FSM state encoding and
// default comma-detect constants for 10-bit abcdeifghj words.
package lvds_align_pkg;

  typedef enum logic [2:0] {
    WAIT    = 3'd0,
    SEARCH  = 3'd1,
    SLIP    = 3'd2,
    HOLD    = 3'd3,
    CONFIRM = 3'd4,
    SYNC    = 3'd5
  } alignState_t;

  // Seven-bit comma 0011111 in abcdeif; the complement 1100000 also matches.
  localparam logic [9:0] COMMA_MASK_DEF = 10'h3F8;
  localparam logic [9:0] COMMA_PAT_DEF  = 10'h0F8;

endpackage

// File: rtl/lvds_lock_seq.sv
// Deserialiser reset sequencer: counts cycles of PLL lock and releases the
// receiver reset at half scale and the data-align reset at three-quarter scale.
module lvds_lock_seq #(
  parameter int LOCK_W = 12
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_PllLocked,
  output logic o_RxReset,
  output logic o_CdaReset
);

  logic [LOCK_W-1:0] lockCnt;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L || !i_PllLocked) begin
      lockCnt <= '0;
    end else if (lockCnt != '1) begin
      lockCnt <= lockCnt + LOCK_W'(1);
    end
  end

  assign o_RxReset  = ~lockCnt[LOCK_W-1];
  assign o_CdaReset = (lockCnt[LOCK_W-1 -: 2] != 2'b11);

endmodule

// File: rtl/lvds_rx_word_align.sv
// Soft-LVDS SGMII word aligner: sequences deserialiser resets, hunts commas with
// bit-slip, and tracks loss of sync. Define LVDS_ALIGN_STATS_EN for slip/loss totals.
module lvds_rx_word_align
  import lvds_align_pkg::*;
#(
  parameter int              DW         = 10,
  parameter logic [DW-1:0]   COMMA_MASK = DW'(COMMA_MASK_DEF),
  parameter logic [DW-1:0]   COMMA_PAT  = DW'(COMMA_PAT_DEF),
  parameter int              LOCK_W     = 12,
  parameter int              SEARCH_TMO = 64,
  parameter int              SLIP_HOLD  = 4,
  parameter int              SYNC_CNT   = 4,
  parameter int              ERR_LIMIT  = 4,
  parameter int              ERR_DECAY  = 16
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_PllLocked,
  input  logic [DW-1:0]           iv_RxData,
  input  logic                    i_CodeErr,
  output logic                    o_RxReset,
  output logic                    o_CdaReset,
  output logic                    o_BitSlip,
  output logic                    o_Synced,
  output logic [$clog2(DW)-1:0]   ov_SlipPos,
  output logic                    o_LossEvt
`ifdef LVDS_ALIGN_STATS_EN
  ,
  output logic [15:0]             ov16_SlipTotal,
  output logic [15:0]             ov16_LossTotal
`endif
);

  localparam int PW = $clog2(DW);
  localparam int TW = $clog2(SEARCH_TMO + 1);
  localparam int HW = $clog2(SLIP_HOLD + 1);
  localparam int GW = $clog2(SYNC_CNT + 1);
  localparam int SW = $clog2(ERR_LIMIT + 1);
  localparam int RW = $clog2(ERR_DECAY + 1);

  alignState_t   state, nextState;
  logic [TW-1:0] tmoCnt;
  logic [HW-1:0] holdCnt;
  logic [GW-1:0] goodCnt;
  logic [SW-1:0] scoreCnt;
  logic [RW-1:0] runCnt;
  logic [DW-1:0] maskedData;
  logic          comma;
  logic          tmoExpired;
  logic          cdaReset;
  logic          lossNow;

  lvds_lock_seq #(
    .LOCK_W(LOCK_W)
  ) u_lockSeq (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_PllLocked(i_PllLocked),
    .o_RxReset  (o_RxReset),
    .o_CdaReset (cdaReset)
  );

  assign o_CdaReset = cdaReset;

  assign maskedData = iv_RxData & COMMA_MASK;
  assign comma      = (maskedData == COMMA_PAT) || (maskedData == (~COMMA_PAT & COMMA_MASK));
  assign tmoExpired = (tmoCnt == TW'(SEARCH_TMO - 1));
  assign lossNow    = (state == SYNC) && (nextState == SEARCH);

  always_comb begin
    nextState = state;
    o_BitSlip = 1'b0;
    o_Synced  = 1'b0;
    case (state)
      WAIT:    if (!cdaReset) nextState = SEARCH;
      SEARCH: begin
        if (comma)           nextState = CONFIRM;
        else if (tmoExpired) nextState = SLIP;
      end
      SLIP: begin
        o_BitSlip = 1'b1;
        nextState = HOLD;
      end
      HOLD:    if (holdCnt == HW'(SLIP_HOLD - 1)) nextState = SEARCH;
      // A code error outranks a coincident comma while confirming alignment.
      CONFIRM: begin
        if (i_CodeErr) begin
          nextState = SLIP;
        end else if (comma) begin
          if (goodCnt == GW'(SYNC_CNT - 1)) nextState = SYNC;
        end else if (tmoExpired) begin
          nextState = SLIP;
        end
      end
      SYNC: begin
        o_Synced = 1'b1;
        if (i_CodeErr && (scoreCnt == SW'(ERR_LIMIT - 1))) nextState = SEARCH;
      end
      default: nextState = WAIT;
    endcase
    if (!i_PllLocked) nextState = WAIT;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state      <= WAIT;
      tmoCnt     <= '0;
      holdCnt    <= '0;
      goodCnt    <= '0;
      scoreCnt   <= '0;
      runCnt     <= '0;
      ov_SlipPos <= '0;
      o_LossEvt  <= 1'b0;
    end else begin
      state     <= nextState;
      o_LossEvt <= lossNow;

      if ((state == SEARCH || state == CONFIRM) && nextState == state && !comma)
        tmoCnt <= tmoCnt + TW'(1);
      else
        tmoCnt <= '0;

      holdCnt <= (state == HOLD && nextState == HOLD) ? holdCnt + HW'(1) : '0;

      // Entering CONFIRM from SEARCH counts the triggering comma as the first good one.
      if (nextState != CONFIRM) goodCnt <= '0;
      else if (comma)           goodCnt <= goodCnt + GW'(1);

      if (state == SYNC && nextState == SYNC) begin
        if (i_CodeErr) begin
          scoreCnt <= scoreCnt + SW'(1);
          runCnt   <= '0;
        end else if (runCnt == RW'(ERR_DECAY - 1)) begin
          if (scoreCnt != '0) scoreCnt <= scoreCnt - SW'(1);
          runCnt <= '0;
        end else begin
          runCnt <= runCnt + RW'(1);
        end
      end else begin
        scoreCnt <= '0;
        runCnt   <= '0;
      end

      if (state == WAIT || lossNow)
        ov_SlipPos <= '0;
      else if (state == SLIP)
        ov_SlipPos <= (ov_SlipPos == PW'(DW - 1)) ? '0 : ov_SlipPos + PW'(1);
    end
  end

`ifdef LVDS_ALIGN_STATS_EN
  // Totals survive PLL loss; only the block reset clears them.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      ov16_SlipTotal <= '0;
      ov16_LossTotal <= '0;
    end else begin
      if (state == SLIP && ov16_SlipTotal != 16'hFFFF) ov16_SlipTotal <= ov16_SlipTotal + 16'd1;
      if (lossNow && ov16_LossTotal != 16'hFFFF)       ov16_LossTotal <= ov16_LossTotal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// Directed scoreboard bench for lvds_rx_word_align: lock sequencing, comma hunt,
// slip position wrap, loss of sync, error decay and PLL drop.
module tb_lvds_rx_word_align;
  import lvds_align_pkg::*;

  localparam int DW         = 10;
  localparam int SEARCH_TMO = 64;
  localparam int SLIP_HOLD  = 4;
  localparam logic [19:0] RING = {10'h0FA, 10'h245};

  logic          i_Clk = 1'b0;
  logic          i_Rst_L, i_PllLocked, i_CodeErr;
  logic [DW-1:0] iv_RxData;
  logic          o_RxReset, o_CdaReset, o_BitSlip, o_Synced, o_LossEvt;
  logic [3:0]    ov_SlipPos;
`ifdef LVDS_ALIGN_STATS_EN
  logic [15:0]   ov16_SlipTotal, ov16_LossTotal;
`endif

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } expItem_t;

  expItem_t sbq[$];
  int checks = 0, failures = 0;
  int mode, mis, wordIdx, cyc, slipCount, lastSlipCyc, minSpacing, commaCount;
  int rxFall, cdaFall, searchAt, maxScore, drops, base;

  lvds_rx_word_align dut (
    .i_Clk         (i_Clk),
    .i_Rst_L       (i_Rst_L),
    .i_PllLocked   (i_PllLocked),
    .iv_RxData     (iv_RxData),
    .i_CodeErr     (i_CodeErr),
    .o_RxReset     (o_RxReset),
    .o_CdaReset    (o_CdaReset),
    .o_BitSlip     (o_BitSlip),
    .o_Synced      (o_Synced),
    .ov_SlipPos    (ov_SlipPos),
    .o_LossEvt     (o_LossEvt)
`ifdef LVDS_ALIGN_STATS_EN
    ,
    .ov16_SlipTotal(ov16_SlipTotal),
    .ov16_LossTotal(ov16_LossTotal)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  // Serial /I2/ stream (K28.5 RD-, D16.2 RD+) sampled at a bit offset m.
  function automatic logic [DW-1:0] ringWord(input int k, input int m);
    logic [39:0] two;
    int          start;
    two   = {RING, RING};
    start = (10 * (k % 2) + m) % 20;
    return two[39 - start -: 10];
  endfunction

  function automatic logic isComma(input logic [DW-1:0] w);
    logic [DW-1:0] mw;
    mw = w & 10'h3F8;
    return (mw == 10'h0F8) || (mw == 10'h300);
  endfunction

  task automatic applyStimulus(input logic rst, input logic pll, input logic err);
    i_Rst_L     = rst;
    i_PllLocked = pll;
    i_CodeErr   = err;
  endtask

  task automatic expectVal(input string tag, input logic [31:0] v);
    expItem_t it;
    it.tag = tag;
    it.exp = v;
    sbq.push_back(it);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    expItem_t it;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=%0d expected=entry", obs);
    end else begin
      it = sbq.pop_front();
      assert (obs === it.exp) else begin
        failures++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", it.tag, obs, it.exp);
      end
    end
  endtask

  // One word clock: the deserialiser model reacts to a slip seen on this edge.
  task automatic tick();
    if (isComma(iv_RxData) && (dut.state == SEARCH || dut.state == CONFIRM)) commaCount++;
    @(posedge i_Clk);
    #1;
    cyc++;
    if (o_BitSlip) begin
      slipCount++;
      if (lastSlipCyc >= 0 && (cyc - lastSlipCyc) < minSpacing) minSpacing = cyc - lastSlipCyc;
      lastSlipCyc = cyc;
      mis         = (mis + DW - 1) % DW;
      commaCount  = 0;
    end
    wordIdx++;
    iv_RxData = (mode == 1) ? ringWord(wordIdx, mis) : 10'h155;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mode = 1; mis = 3; wordIdx = 0; cyc = 0;
    slipCount = 0; lastSlipCyc = -1; minSpacing = 1_000_000; commaCount = 0;
    rxFall = -1; cdaFall = -1; searchAt = -1;
    iv_RxData = ringWord(0, 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) tick();

    expectVal("reset_rxreset", 1);  checkOutput(32'(o_RxReset));
    expectVal("reset_cdareset", 1); checkOutput(32'(o_CdaReset));
    expectVal("reset_bitslip", 0);  checkOutput(32'(o_BitSlip));
    expectVal("reset_synced", 0);   checkOutput(32'(o_Synced));
    expectVal("reset_slippos", 0);  checkOutput(32'(ov_SlipPos));
    expectVal("reset_lossevt", 0);  checkOutput(32'(o_LossEvt));

    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int n = 1; n <= 3073; n++) begin
      tick();
      if (rxFall < 0 && !o_RxReset) rxFall = n;
      if (cdaFall < 0 && !o_CdaReset) cdaFall = n;
      if (searchAt < 0 && dut.state == SEARCH) searchAt = n;
    end
    expectVal("rxreset_fall_cycle", 2048);  checkOutput(32'(rxFall));
    expectVal("cdareset_fall_cycle", 3072); checkOutput(32'(cdaFall));
    expectVal("search_entry_cycle", 3073);  checkOutput(32'(searchAt));

    for (int i = 0; i < 1000 && !o_Synced; i++) tick();
    expectVal("hunt_synced", 1);         checkOutput(32'(o_Synced));
    expectVal("hunt_slip_count", 3);     checkOutput(32'(slipCount));
    expectVal("hunt_slip_spacing_ok", 1);
    checkOutput(32'(minSpacing >= SLIP_HOLD + SEARCH_TMO));
    expectVal("hunt_slippos", 3);        checkOutput(32'(ov_SlipPos));
    expectVal("hunt_commas_to_sync", 4); checkOutput(32'(commaCount));

    for (int e = 0; e < 4; e++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (e < 3) begin
        expectVal("isolated_err_still_synced", 1); checkOutput(32'(o_Synced));
        repeat (4) tick();
      end
    end
    expectVal("loss_evt_pulse", 1);     checkOutput(32'(o_LossEvt));
    expectVal("loss_synced_low", 0);    checkOutput(32'(o_Synced));
    expectVal("loss_state_search", 32'(SEARCH)); checkOutput(32'(dut.state));
    expectVal("loss_slippos_clear", 0); checkOutput(32'(ov_SlipPos));
    tick();
    expectVal("loss_evt_single", 0);    checkOutput(32'(o_LossEvt));

    for (int i = 0; i < 100 && !o_Synced; i++) tick();
    expectVal("resync_synced", 1);      checkOutput(32'(o_Synced));
    expectVal("resync_no_slips", 3);    checkOutput(32'(slipCount));
    expectVal("resync_slippos", 0);     checkOutput(32'(ov_SlipPos));

    maxScore = 0; drops = 0;
    for (int it = 0; it < 8; it++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (int'(dut.scoreCnt) > maxScore) maxScore = int'(dut.scoreCnt);
      if (!o_Synced) drops++;
      for (int j = 0; j < 19; j++) begin
        tick();
        if (int'(dut.scoreCnt) > maxScore) maxScore = int'(dut.scoreCnt);
        if (!o_Synced) drops++;
      end
    end
    expectVal("decay_max_score", 1);    checkOutput(32'(maxScore));
    expectVal("decay_sync_drops", 0);   checkOutput(32'(drops));
    expectVal("decay_score_zero", 0);   checkOutput(32'(dut.scoreCnt));

    for (int e = 0; e < 4; e++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    mode = 0;
    iv_RxData = 10'h155;
    expectVal("burst_loss_evt", 1);     checkOutput(32'(o_LossEvt));

    for (int s = 1; s <= 11; s++) begin
      base = slipCount;
      for (int i = 0; i < 200 && slipCount == base; i++) tick();
      tick();
      expectVal($sformatf("wrap_slippos_%0d", s), 32'(s % DW));
      checkOutput(32'(ov_SlipPos));
    end

    mode = 1; mis = 0;
    for (int i = 0; i < 300 && dut.state != CONFIRM; i++) tick();
    expectVal("reach_confirm", 32'(CONFIRM)); checkOutput(32'(dut.state));
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    expectVal("plldrop_rxreset", 1);    checkOutput(32'(o_RxReset));
    expectVal("plldrop_cdareset", 1);   checkOutput(32'(o_CdaReset));
    expectVal("plldrop_bitslip", 0);    checkOutput(32'(o_BitSlip));
    expectVal("plldrop_synced", 0);     checkOutput(32'(o_Synced));
    expectVal("plldrop_state_wait", 32'(WAIT)); checkOutput(32'(dut.state));
    tick();
    expectVal("plldrop_held_wait", 32'(WAIT)); checkOutput(32'(dut.state));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
